// File: rtl/pulse_synth_multi_pkg.sv
// Shared definitions for the multi-channel harmonic pulse synthesiser.
// Holds the ceiling-log2 helper, the counter-width helpers used to size the
// debounce/repeat counters and the channel-count mixer, and the default
// timing constants for the board build.
package pulse_synth_multi_pkg;

  // Smallest w such that 2**w >= value (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((longint'(1) << result) < longint'(value)) begin
      result++;
    end
    return result;
  endfunction

  // Width of a counter that must hold 0..max_count, never narrower than 1 bit.
  function automatic int cnt_w(input int max_count);
    int w;
    w = clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the mixer count, which ranges 0..n_ch.
  function automatic int count_w(input int n_ch);
    return clog2(n_ch + 1);
  endfunction

  localparam int DEF_DEB_CYCLES    = 500000;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;

  localparam int DEF_DEB_W = cnt_w(DEF_DEB_CYCLES);
  localparam int DEF_REP_W = cnt_w((DEF_REPEAT_DELAY > DEF_REPEAT_PERIOD) ?
                                   DEF_REPEAT_DELAY : DEF_REPEAT_PERIOD);

endpackage

// File: rtl/pulse_synth_multi_button.sv
// button_repeat_conditioner: turns one raw push-button into step pulses.
// The button is synchronised through two flops, debounced (the stable level
// only flips after the synchronised input has disagreed with it for
// DEB_CYCLES consecutive cycles), and then converted to one-cycle steps:
// one on press, a first repeat REPEAT_DELAY cycles later, then one every
// REPEAT_PERIOD cycles while held. Release cancels repeating at once.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   btn_raw - raw, asynchronous button level
//   step    - registered one-cycle step pulse
module button_repeat_conditioner
  import pulse_synth_multi_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic step
);

  localparam int DEB_W   = cnt_w(DEB_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = cnt_w(REP_MAX);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             repeating_q, repeating_d;
  logic             step_q, step_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;

    // Any cycle where the input agrees with the stable level restarts the
    // debounce window from zero.
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = ~stable_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    // The repeat counter measures time since the last step; it is forced to
    // zero whenever the button is not held, so release cancels repeating.
    step_d      = 1'b0;
    rep_cnt_d   = '0;
    repeating_d = 1'b0;
    if (stable_d && !stable_q) begin
      step_d = 1'b1;
    end else if (stable_d && stable_q) begin
      repeating_d = repeating_q;
      rep_cnt_d   = rep_cnt_q + 1'b1;
      if ((!repeating_q && rep_cnt_q == DELAY_LAST) ||
          ( repeating_q && rep_cnt_q == PERIOD_LAST)) begin
        step_d      = 1'b1;
        rep_cnt_d   = '0;
        repeating_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      repeating_q <= 1'b0;
      step_q      <= 1'b0;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      repeating_q <= repeating_d;
      step_q      <= step_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/pulse_synth_multi.sv
// pulse_synth_multi: N_CH harmonic square-wave channels sharing one
// button-adjusted frequency scale, mixed into a single-bit output by a
// first-order sigma-delta modulator. Channel k runs at (k+1) times the base
// frequency; each channel is gated by its own enable switch.
// Ports:
//   sysclk    - system clock
//   rst_n     - asynchronous active-low reset
//   Enable_SW - per-channel enable switches (asynchronous)
//   Bt_Plus   - raw increment button (asynchronous)
//   Bt_Minus  - raw decrement button (asynchronous)
//   Scale     - current frequency scale
//   Pulse     - registered sigma-delta mixed output
module pulse_synth_multi
  import pulse_synth_multi_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SCALE_W       = 6,
  parameter int SCALE_INIT    = 0,
  parameter int ACC_W         = 24,
  parameter int BASE_INC      = 16,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    Enable_SW,
  input  logic               Bt_Plus,
  input  logic               Bt_Minus,
  output logic [SCALE_W-1:0] Scale,
  output logic               Pulse
);

  localparam int COUNT_W = count_w(N_CH);
  // The sigma-delta sum reaches at most 2*N_CH-1, one bit wider than count.
  localparam int SD_W    = COUNT_W + 1;
  localparam logic [SCALE_W-1:0] SCALE_MAX = '1;

  // The highest increment must stay below half the accumulator range, or the
  // top harmonic would alias instead of producing a square wave.
  if (((longint'(1) << SCALE_W) * longint'(N_CH) * longint'(BASE_INC)) >=
      (longint'(1) << (ACC_W - 1))) begin : g_param_check
    $error("pulse_synth_multi: increment range exceeds half the accumulator");
  end

  logic               plus_step, minus_step;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [N_CH-1:0]    en_s1_q, en_s1_d;
  logic [N_CH-1:0]    en_s2_q, en_s2_d;
  logic [ACC_W-1:0]   acc_q [N_CH];
  logic [ACC_W-1:0]   acc_d [N_CH];
  logic [ACC_W-1:0]   inc   [N_CH];
  logic [N_CH-1:0]    ch_bit;
  logic [COUNT_W-1:0] count;
  logic [SD_W-1:0]    sd_sum;
  logic [SD_W-1:0]    sd_acc_q, sd_acc_d;
  logic               pulse_q, pulse_d;

  button_repeat_conditioner #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_plus (
    .clk    (sysclk),
    .rst_n  (rst_n),
    .btn_raw(Bt_Plus),
    .step   (plus_step)
  );

  button_repeat_conditioner #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_minus (
    .clk    (sysclk),
    .rst_n  (rst_n),
    .btn_raw(Bt_Minus),
    .step   (minus_step)
  );

  // Disabling a channel clears its phase so re-enabling starts at phase 0.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign inc[k]    = ACC_W'((int'(scale_q) + 1) * (k + 1) * BASE_INC);
    assign acc_d[k]  = en_s2_q[k] ? (acc_q[k] + inc[k]) : '0;
    assign ch_bit[k] = acc_q[k][ACC_W-1] & en_s2_q[k];
  end

  always_comb begin
    // Simultaneous plus and minus steps cancel; both ends saturate.
    scale_d = scale_q;
    if (plus_step && !minus_step && scale_q != SCALE_MAX) begin
      scale_d = scale_q + 1'b1;
    end else if (minus_step && !plus_step && scale_q != '0) begin
      scale_d = scale_q - 1'b1;
    end

    en_s1_d = Enable_SW;
    en_s2_d = en_s1_q;

    count = '0;
    for (int k = 0; k < N_CH; k++) begin
      count = count + COUNT_W'(ch_bit[k]);
    end

    // First-order sigma-delta: the residue carries the fractional part so the
    // long-run density of Pulse equals count/N_CH.
    sd_sum = sd_acc_q + SD_W'(count);
    if (sd_sum >= SD_W'(N_CH)) begin
      sd_acc_d = sd_sum - SD_W'(N_CH);
      pulse_d  = 1'b1;
    end else begin
      sd_acc_d = sd_sum;
      pulse_d  = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q  <= SCALE_W'(SCALE_INIT);
      en_s1_q  <= '0;
      en_s2_q  <= '0;
      sd_acc_q <= '0;
      pulse_q  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      scale_q  <= scale_d;
      en_s1_q  <= en_s1_d;
      en_s2_q  <= en_s2_d;
      sd_acc_q <= sd_acc_d;
      pulse_q  <= pulse_d;
      for (int k = 0; k < N_CH; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign Scale = scale_q;
  assign Pulse = pulse_q;

endmodule

// File: tb/tb_pulse_synth_multi.sv
// Self-checking bench for pulse_synth_multi, built with short debounce and
// repeat timings and an 10-bit accumulator so every feature is reachable in
// a few thousand cycles. Button behaviour is checked from a table of presses
// and from random presses scored by a step-count model; Pulse is checked
// every cycle against an arithmetic model of the channels and modulator.
module tb_pulse_synth_multi;

  localparam int N_CH          = 4;
  localparam int SCALE_W       = 6;
  localparam int SCALE_INIT    = 0;
  localparam int ACC_W         = 10;
  localparam int BASE_INC      = 1;
  localparam int DEB_CYCLES    = 4;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 5;
  localparam int SCALE_TOP     = (1 << SCALE_W) - 1;
  localparam int ACC_RANGE     = 1 << ACC_W;
  localparam int GAP           = 15;

  logic               sysclk = 1'b0;
  logic               rst_n;
  logic [N_CH-1:0]    Enable_SW;
  logic               Bt_Plus;
  logic               Bt_Minus;
  logic [SCALE_W-1:0] Scale;
  logic               Pulse;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model state: unbounded phases, delayed enables, modulator residue.
  longint phase [N_CH];
  bit     en1 [N_CH];
  bit     en2 [N_CH];
  int     sdErr;
  bit     modelPulse;
  int     modelScale;

  typedef struct {
    bit    plus;
    bit    minus;
    int    len;
    int    expScale;
    string name;
  } btn_vec_t;

  btn_vec_t vecs [15];

  always #5 sysclk = ~sysclk;

  pulse_synth_multi #(
    .N_CH         (N_CH),
    .SCALE_W      (SCALE_W),
    .SCALE_INIT   (SCALE_INIT),
    .ACC_W        (ACC_W),
    .BASE_INC     (BASE_INC),
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .Enable_SW(Enable_SW),
    .Bt_Plus  (Bt_Plus),
    .Bt_Minus (Bt_Minus),
    .Scale    (Scale),
    .Pulse    (Pulse)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // A press held for len cycles keeps the debounced level high for len cycles:
  // one step at press, one at REPEAT_DELAY, then one per REPEAT_PERIOD.
  function automatic int stepsFor(input int len);
    int n;
    if (len < DEB_CYCLES) return 0;
    n = 1;
    if (len > REPEAT_DELAY) n += 1 + (len - 1 - REPEAT_DELAY) / REPEAT_PERIOD;
    return n;
  endfunction

  function automatic int nextScale(input int cur, input bit plus, input bit minus, input int len);
    int n;
    if (plus && minus) return cur;
    n = stepsFor(len);
    if (plus) return (cur + n > SCALE_TOP) ? SCALE_TOP : cur + n;
    if (minus) return (cur - n < 0) ? 0 : cur - n;
    return cur;
  endfunction

  // Called at a negedge; holds the buttons for exactly len sampling edges.
  task automatic applyStimulus(input bit plus, input bit minus, input int len);
    Bt_Plus  = plus;
    Bt_Minus = minus;
    repeat (len) @(negedge sysclk);
    Bt_Plus  = 1'b0;
    Bt_Minus = 1'b0;
    repeat (GAP) @(negedge sysclk);
  endtask

  task automatic resetModel();
    for (int k = 0; k < N_CH; k++) begin
      phase[k] = 0;
      en1[k]   = 1'b0;
      en2[k]   = 1'b0;
    end
    sdErr      = 0;
    modelPulse = 1'b0;
  endtask

  // Advances the model across the next rising edge, then checks Pulse at the
  // following falling edge. Must be entered at a negedge.
  task automatic stepCycle();
    int cnt;
    int s;
    cnt = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (en2[k] && ((phase[k] % ACC_RANGE) >= (ACC_RANGE / 2))) cnt++;
    end
    s = sdErr + cnt;
    if (s >= N_CH) begin
      sdErr      = s - N_CH;
      modelPulse = 1'b1;
    end else begin
      sdErr      = s;
      modelPulse = 1'b0;
    end
    for (int k = 0; k < N_CH; k++) begin
      phase[k] = en2[k] ? phase[k] + longint'((modelScale + 1) * (k + 1) * BASE_INC) : 0;
      en2[k]   = en1[k];
      en1[k]   = Enable_SW[k];
    end
    @(negedge sysclk);
    checkOutput("pulse", Pulse, modelPulse);
  endtask

  initial begin
    int pulseCount;
    int kind;
    int len;

    vecs[0]  = '{1'b1, 1'b0,   3,  0, "glitch_3"};
    vecs[1]  = '{1'b1, 1'b0,   4,  1, "min_press_4"};
    vecs[2]  = '{1'b1, 1'b0,  10,  2, "press_10"};
    vecs[3]  = '{1'b1, 1'b0, 303, 60, "hold_to_60"};
    vecs[4]  = '{1'b1, 1'b0, 100, 63, "saturate_top"};
    vecs[5]  = '{1'b0, 1'b1,  20, 62, "minus_no_repeat"};
    vecs[6]  = '{1'b0, 1'b1,  21, 60, "minus_first_repeat"};
    vecs[7]  = '{1'b0, 1'b1,  26, 57, "minus_second_repeat"};
    vecs[8]  = '{1'b1, 1'b1,  30, 57, "both_at_57"};
    vecs[9]  = '{1'b0, 1'b1, 340,  0, "hold_to_0"};
    vecs[10] = '{1'b0, 1'b1,  50,  0, "saturate_bottom"};
    vecs[11] = '{1'b1, 1'b0,  48,  7, "plus_48"};
    vecs[12] = '{1'b1, 1'b0,  14,  8, "plus_14"};
    vecs[13] = '{1'b1, 1'b0,  21, 10, "plus_21"};
    vecs[14] = '{1'b1, 1'b1,  30, 10, "both_at_10"};

    // Reset held with both buttons pressed and every channel enabled.
    rst_n     = 1'b0;
    Bt_Plus   = 1'b1;
    Bt_Minus  = 1'b1;
    Enable_SW = '1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge sysclk);
      checkOutput("reset_scale", Scale, 0);
      checkOutput("reset_pulse", Pulse, 0);
    end
    Bt_Plus   = 1'b0;
    Bt_Minus  = 1'b0;
    Enable_SW = '0;
    repeat (4) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (12) @(negedge sysclk);
    checkOutput("idle_scale", Scale, 0);

    // Mixing at Scale 0, with a channel dropped and restored mid-run.
    modelScale = 0;
    resetModel();
    Enable_SW = '1;
    repeat (300) stepCycle();
    Enable_SW[0] = 1'b0;
    repeat (3) stepCycle();
    checkOutput("acc0_cleared", u_dut.acc_q[0], 0);
    repeat (50) stepCycle();
    Enable_SW[0] = 1'b1;
    repeat (200) stepCycle();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) Enable_SW = N_CH'($urandom);
      stepCycle();
    end

    // Button table: debounce, repeat timing, saturation, simultaneous presses.
    Enable_SW = '0;
    repeat (5) @(negedge sysclk);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].plus, vecs[i].minus, vecs[i].len);
      checkOutput(vecs[i].name, Scale, vecs[i].expScale);
    end

    // Random presses scored by the step-count model.
    modelScale = 10;
    for (int i = 0; i < 10; i++) begin
      kind = int'($urandom_range(0, 2));
      len  = int'($urandom_range(1, 60));
      applyStimulus(kind != 1, kind != 0, len);
      modelScale = nextScale(modelScale, kind != 1, kind != 0, len);
      checkOutput("random_press", Scale, modelScale);
    end

    // Frequency checks at Scale 1.
    rst_n = 1'b0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("scale_one", Scale, 1);
    modelScale = 1;
    resetModel();

    // ch0 alone: increment 2, period 512, Pulse density 1/4 while high.
    Enable_SW = 4'b0001;
    repeat (600) stepCycle();
    pulseCount = 0;
    for (int i = 0; i < 512; i++) begin
      stepCycle();
      pulseCount += int'(Pulse);
    end
    checkOutput("ch0_pulses_per_period", pulseCount, 64);

    // ch1 alone: increment 4, period 256.
    Enable_SW = 4'b0010;
    repeat (300) stepCycle();
    pulseCount = 0;
    for (int i = 0; i < 256; i++) begin
      stepCycle();
      pulseCount += int'(Pulse);
    end
    checkOutput("ch1_pulses_per_period", pulseCount, 32);

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    Enable_SW = '1;
    repeat (40) stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_scale", Scale, 0);
    checkOutput("async_reset_pulse", Pulse, 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    repeat (4) @(negedge sysclk);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
